// File: rtl/cache_meta_lru_array.sv
// rtl/cache_meta_lru_array.sv - N-way tag/valid/true-LRU metadata array with victim select and flush sweep
// Optional per-way dirty tracking (wr_hit, victim_dirty) when META_DIRTY_EN is defined.
module cache_meta_lru_array #(
  parameter int WAYS  = 4,
  parameter int SETS  = 32,
  parameter int TAG_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lookup_en,
  input  logic [$clog2(SETS)-1:0]  lookup_idx,
  input  logic [TAG_W-1:0]         lookup_tag,
  output logic                     hit,
  output logic [WAYS-1:0]          hit_way,
  output logic [WAYS-1:0]          victim_way,
  input  logic                     fill_en,
  input  logic [WAYS-1:0]          fill_way,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic                     flush_done
`ifdef META_DIRTY_EN
  ,
  input  logic                     wr_hit,
  output logic                     victim_dirty
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               done_d;

  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [WAYS-1:0]    valid_q [SETS];
  logic [AGE_W-1:0]   age_q   [SETS][WAYS];
`ifdef META_DIRTY_EN
  logic [WAYS-1:0]    dirty_q [SETS];
`endif

  logic [WAYS-1:0]    match;
  logic [AGE_W-1:0]   hit_idx, vic_idx, fill_idx, touch_idx, old_age;
  logic [AGE_W-1:0]   age_new [WAYS];
  logic               idle, do_fill, do_touch_hit;

  assign idle       = (state_q == IDLE);
  assign flush_busy = (state_q == SWEEP);

  always_comb begin
    match    = '0;
    hit_idx  = '0;
    vic_idx  = '0;
    fill_idx = '0;
    for (int w = 0; w < WAYS; w++)
      match[w] = valid_q[lookup_idx][w] && (tag_q[lookup_idx][w] == lookup_tag);
    for (int w = WAYS - 1; w >= 0; w--)
      if (match[w]) hit_idx = AGE_W'(w);
    // Oldest way is the fallback; any invalid way (lowest index) overrides it.
    for (int w = 0; w < WAYS; w++)
      if (age_q[lookup_idx][w] == '0) vic_idx = AGE_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[lookup_idx][w]) vic_idx = AGE_W'(w);
    for (int w = 0; w < WAYS; w++)
      if (fill_way[w]) fill_idx = AGE_W'(w);
  end

  assign hit        = lookup_en && idle && (|match);
  assign hit_way    = hit ? (WAYS'(1) << hit_idx) : '0;
  assign victim_way = WAYS'(1) << vic_idx;

  // A flush request pre-empts both fill and hit promotion in the same cycle.
  assign do_fill      = idle && !flush_req && fill_en && $onehot(fill_way);
  assign do_touch_hit = idle && !flush_req && !fill_en && hit;
  assign touch_idx    = do_fill ? fill_idx : hit_idx;
  assign old_age      = age_q[lookup_idx][touch_idx];

  always_comb begin
    for (int v = 0; v < WAYS; v++) begin
      age_new[v] = age_q[lookup_idx][v];
      if (AGE_W'(v) == touch_idx)
        age_new[v] = AGE_W'(WAYS - 1);
      else if (age_q[lookup_idx][v] > old_age)
        age_new[v] = age_q[lookup_idx][v] - AGE_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(SETS - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      flush_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      flush_done <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_fill) tag_q[lookup_idx][fill_idx] <= lookup_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      if (flush_busy) valid_q[ptr_q] <= '0;
      if (do_fill) valid_q[lookup_idx][fill_idx] <= 1'b1;
      if (do_fill || do_touch_hit)
        for (int v = 0; v < WAYS; v++) age_q[lookup_idx][v] <= age_new[v];
    end
  end

`ifdef META_DIRTY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) dirty_q[s] <= '0;
    end else begin
      if (flush_busy) dirty_q[ptr_q] <= '0;
      if (wr_hit && hit) dirty_q[lookup_idx][hit_idx] <= 1'b1;
      if (do_fill) dirty_q[lookup_idx][fill_idx] <= 1'b0;
    end
  end

  assign victim_dirty = dirty_q[lookup_idx][vic_idx] && valid_q[lookup_idx][vic_idx];
`endif

  a_single_match: assert property (@(posedge clk) disable iff (rst)
    (lookup_en && idle) |-> $onehot0(match));
  a_fill_onehot: assert property (@(posedge clk) disable iff (rst)
    (fill_en && idle && !flush_req) |-> $onehot(fill_way));
endmodule

// File: tb/tb_cache_meta_lru_array.sv
// tb/tb_cache_meta_lru_array.sv - self-checking bench for cache_meta_lru_array
// Recency-order reference model checked every cycle, plus directed literal expectations.
module tb_cache_meta_lru_array;
  localparam int WAYS = 4, SETS = 32, TAG_W = 7, IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst, lookup_en, fill_en, flush_req;
  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [WAYS-1:0]  fill_way, hit_way, victim_way;
  logic             hit, flush_busy, flush_done;
`ifdef META_DIRTY_EN
  logic             wr_hit, victim_dirty;
`endif

  int n_pass = 0, n_total = 0;

  cache_meta_lru_array #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .lookup_en(lookup_en), .lookup_idx(lookup_idx),
    .lookup_tag(lookup_tag), .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
    .fill_en(fill_en), .fill_way(fill_way), .flush_req(flush_req),
    .flush_busy(flush_busy), .flush_done(flush_done)
`ifdef META_DIRTY_EN
    , .wr_hit(wr_hit), .victim_dirty(victim_dirty)
`endif
  );

  always #5 clk = ~clk;

  // Model: per set, ways listed least-recent first; a way's age is its list position.
  bit m_valid [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_order [SETS][WAYS];
  bit m_busy, m_done;
  int m_sweep;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int m_match();
    for (int w = 0; w < WAYS; w++)
      if (m_valid[lookup_idx][w] && m_tag[lookup_idx][w] == int'(lookup_tag)) return w;
    return -1;
  endfunction

  function automatic int m_victim();
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[lookup_idx][w]) return w;
    return m_order[lookup_idx][0];
  endfunction

  task automatic m_touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < WAYS; i++) if (m_order[s][i] == w) p = i;
    for (int i = p; i < WAYS - 1; i++) m_order[s][i] = m_order[s][i + 1];
    m_order[s][WAYS - 1] = w;
  endtask

  always @(posedge clk) begin
    int mh;
    mh = m_match();
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          m_valid[s][w] = 1'b0;
          m_order[s][w] = w;
        end
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        for (int w = 0; w < WAYS; w++) m_valid[m_sweep][w] = 1'b0;
        if (m_sweep == SETS - 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else m_sweep++;
      end else if (flush_req) begin
        m_busy  = 1'b1;
        m_sweep = 0;
      end else if (fill_en) begin
        if ($countones(fill_way) == 1) begin
          for (int w = 0; w < WAYS; w++)
            if (fill_way[w]) begin
              m_tag[lookup_idx][w]   = int'(lookup_tag);
              m_valid[lookup_idx][w] = 1'b1;
              m_touch(int'(lookup_idx), w);
            end
        end
      end else if (lookup_en && mh >= 0) begin
        m_touch(int'(lookup_idx), mh);
      end
    end
  end

  always @(negedge clk) begin
    int mh;
    bit eh;
    if (!rst) begin
      mh = m_match();
      eh = lookup_en && !m_busy && (mh >= 0);
      check("hit", hit, eh);
      check("hit_way", hit_way, eh ? (1 << mh) : 0);
      check("victim_way", victim_way, 1 << m_victim());
      check("flush_busy", flush_busy, m_busy);
      check("flush_done", flush_done, m_done);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int idx, input int tag, input int w);
    lookup_idx = IDX_W'(idx);
    lookup_tag = TAG_W'(tag);
    fill_way   = WAYS'(1 << w);
    fill_en    = 1'b1;
    cyc();
    fill_en    = 1'b0;
  endtask

  initial begin
    int cnt, bad;
    rst = 1'b1; lookup_en = 1'b0; fill_en = 1'b0; flush_req = 1'b0;
    lookup_idx = '0; lookup_tag = '0; fill_way = '0;
`ifdef META_DIRTY_EN
    wr_hit = 1'b0;
`endif
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    check("reset_busy", flush_busy, 0);
    check("reset_done", flush_done, 0);

    // Test 1: miss then fill way0 then hit
    lookup_en = 1'b1; lookup_idx = 5; lookup_tag = 7'h12;
    #1;
    check("t1_miss", hit, 0);
    check("t1_victim", victim_way, 4'b0001);
    fill_en = 1'b1; fill_way = 4'b0001;
    cyc();
    fill_en = 1'b0;
    #1;
    check("t1_hit", hit, 1);
    check("t1_hit_way", hit_way, 4'b0001);

    // Test 2: full set, hits move LRU victim along
    lookup_en = 1'b0;
    for (int w = 0; w < 4; w++) fill(3, 8'h10 + w, w);
    lookup_en = 1'b1; lookup_tag = 7'h10;
    cyc();
    check("t2_victim_a", victim_way, 4'b0010);
    lookup_tag = 7'h11;
    cyc();
    check("t2_victim_b", victim_way, 4'b0100);
    lookup_en = 1'b0;

    // Test 3: fill way2 and hit way0 in the same cycle; fill wins
    fill(7, 8'h40, 0);
    lookup_en = 1'b1;
    fill(7, 8'h40, 2);
    lookup_en = 1'b0;
    check("t3_age_w0", dut.age_q[7][0], 2);
    check("t3_age_w1", dut.age_q[7][1], 0);
    check("t3_age_w2", dut.age_q[7][2], 3);
    check("t3_age_w3", dut.age_q[7][3], 1);
    check("t3_victim", victim_way, 4'b0010);

`ifdef META_DIRTY_EN
    fill(2, 8'h21, 1);
    lookup_en = 1'b1; lookup_tag = 7'h21; wr_hit = 1'b1;
    cyc();
    wr_hit = 1'b0; lookup_en = 1'b0;
    fill(2, 8'h30, 0);
    fill(2, 8'h32, 2);
    fill(2, 8'h33, 3);
    check("t6_victim", victim_way, 4'b0010);
    check("t6_victim_dirty", victim_dirty, 1);
    fill(2, 8'h31, 1);
    check("t6_victim_dirty_clr", victim_dirty, 0);
`endif

    // Test 4: flush with a colliding fill; count busy window
    fill(0, 8'h01, 0);
    fill(31, 8'h7f, 3);
    lookup_en = 1'b1; lookup_idx = 0; lookup_tag = 7'h01;
    fill_en = 1'b1; fill_way = 4'b0010; flush_req = 1'b1;
    cyc();
    fill_en = 1'b0; flush_req = 1'b0;
    cnt = 0;
    while (flush_busy && cnt < 40) begin
      if (cnt == 5) flush_req = 1'b1;
      if (cnt == 6) flush_req = 1'b0;
      cnt++;
      cyc();
    end
    check("t4_busy_cycles", cnt, 32);
    check("t4_done_pulse", flush_done, 1);
    cyc();
    check("t4_done_clear", flush_done, 0);
    check("t4_set0_miss", hit, 0);
    lookup_idx = 31; lookup_tag = 7'h7f;
    #1;
    check("t4_set31_miss", hit, 0);
    lookup_en = 1'b0;

    // Test 5: reset in the middle of a sweep
    fill(0, 8'h05, 0);
    fill(9, 8'h06, 1);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    repeat (10) cyc();
    check("t5_busy_mid", flush_busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t5_busy_after_rst", flush_busy, 0);
    bad = 0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        if (dut.age_q[s][w] != 2'(w)) bad++;
        if (dut.valid_q[s][w]) bad++;
      end
    check("t5_state_reset", bad, 0);
    lookup_en = 1'b1; lookup_idx = 9; lookup_tag = 7'h06;
    #1;
    check("t5_set9_miss", hit, 0);
    check("t5_set9_victim", victim_way, 4'b0001);
    cyc();
    lookup_en = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
